// File: rtl/group_bcd_counter.sv
// group_bcd_counter
// Counts single-cycle item qualifiers into groups of GROUP_SIZE and keeps a
// decimal (BCD) tally of completed groups. The tally either wraps to zero or
// holds at all nines when it overflows. Overflow is a sticky flag, and
// group_done pulses for one cycle on each completion.

module group_bcd_counter #(
    parameter int GROUP_SIZE = 12,
    parameter int DIGITS     = 2,
    parameter int SATURATE   = 0,
    localparam int ICW       = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  item,
    input  logic                  clear,
    output logic [ICW-1:0]        item_count,
    output logic [4*DIGITS-1:0]   bcd_groups,
    output logic                  group_done,
    output logic                  overflow,
    output logic                  at_max
);

    localparam logic [ICW-1:0] LAST_ITEM = ICW'(GROUP_SIZE - 1);

    logic [4*DIGITS-1:0] tally_inc;
    logic                last_item;

    assign last_item = (item_count == LAST_ITEM);

    // Decimal +1 of the tally: a digit at 9 rolls to 0 and passes the carry upward
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        tally_inc = bcd_groups;
        carry     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            digit = bcd_groups[4*k +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    tally_inc[4*k +: 4] = 4'd0;
                end else begin
                    tally_inc[4*k +: 4] = digit + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Tally is at its ceiling when every digit reads 9
    always_comb begin
        at_max = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_groups[4*k +: 4] != 4'd9) begin
                at_max = 1'b0;
            end
        end
    end

    // Item accumulation, group completion, tally update and sticky overflow
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            item_count <= '0;
            bcd_groups <= '0;
            group_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            group_done <= 1'b0;
            if (item) begin
                if (last_item) begin
                    item_count <= '0;
                    group_done <= 1'b1;
                    if (at_max) begin
                        overflow <= 1'b1;
                        if (SATURATE == 0) begin
                            bcd_groups <= '0;
                        end
                    end else begin
                        bcd_groups <= tally_inc;
                    end
                end else begin
                    item_count <= item_count + ICW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_group_bcd_counter.sv
// Directed bench for group_bcd_counter. Three instances share one stimulus
// stream: defaults (wrap), SATURATE=1, and GROUP_SIZE=1 / DIGITS=1.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_group_bcd_counter;

    logic clk;
    logic reset;
    logic item;
    logic clear;

    logic [3:0] ic0;
    logic [7:0] bcd0;
    logic       gd0, ovf0, max0;

    logic [3:0] ic1;
    logic [7:0] bcd1;
    logic       gd1, ovf1, max1;

    logic [0:0] ic2;
    logic [3:0] bcd2;
    logic       gd2, ovf2, max2;

    int n_cmp = 0;
    int n_err = 0;

    int pulses0 = 0;
    int pulses1 = 0;
    int pulses2 = 0;
    int illegal0 = 0;
    int maxerr0 = 0;

    int base0, base1, base2, ill_base;

    group_bcd_counter #(.GROUP_SIZE(12), .DIGITS(2), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .item(item), .clear(clear),
        .item_count(ic0), .bcd_groups(bcd0), .group_done(gd0),
        .overflow(ovf0), .at_max(max0)
    );

    group_bcd_counter #(.GROUP_SIZE(12), .DIGITS(2), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .item(item), .clear(clear),
        .item_count(ic1), .bcd_groups(bcd1), .group_done(gd1),
        .overflow(ovf1), .at_max(max1)
    );

    group_bcd_counter #(.GROUP_SIZE(1), .DIGITS(1), .SATURATE(0)) dut_one (
        .clk(clk), .reset(reset), .item(item), .clear(clear),
        .item_count(ic2), .bcd_groups(bcd2), .group_done(gd2),
        .overflow(ovf2), .at_max(max2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and digit/at_max sanity monitors
    always @(negedge clk) begin
        if (gd0) pulses0++;
        if (gd1) pulses1++;
        if (gd2) pulses2++;
        if (bcd0[3:0] > 4'd9 || bcd0[7:4] > 4'd9) illegal0++;
        if (max0 !== (bcd0 == 8'h99)) maxerr0++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic items(input int n);
        item = 1'b1;
        repeat (n) @(negedge clk);
        item = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic snap();
        #1;
        base0 = pulses0;
        base1 = pulses1;
        base2 = pulses2;
        ill_base = illegal0;
    endtask

    initial begin
        reset = 1'b0;
        item  = 1'b0;
        clear = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check_val("rst_ic",   32'(ic0),  32'd0);
        check_val("rst_bcd",  32'(bcd0), 32'h00);
        check_val("rst_gd",   32'(gd0),  32'd0);
        check_val("rst_ovf",  32'(ovf0), 32'd0);
        check_val("rst_max",  32'(max0), 32'd0);
        snap();

        // First group of 12
        items(11);
        check_val("g1_ic11",  32'(ic0),  32'd11);
        check_val("g1_bcd11", 32'(bcd0), 32'h00);
        check_val("g1_gd11",  32'(gd0),  32'd0);
        items(1);
        check_val("g1_ic12",  32'(ic0),  32'd0);
        check_val("g1_bcd12", 32'(bcd0), 32'h01);
        check_val("g1_gd12",  32'(gd0),  32'd1);
        @(negedge clk);
        check_val("idle_gd",  32'(gd0),  32'd0);
        check_val("idle_bcd", 32'(bcd0), 32'h01);
        #1;
        check_val("g1_pulses", 32'(pulses0 - base0), 32'd1);

        // 120 items: carry from 09 into 10
        @(negedge clk);
        do_reset();
        snap();
        items(120);
        check_val("c120_bcd", 32'(bcd0), 32'h10);
        check_val("c120_ic",  32'(ic0),  32'd0);
        check_val("c120_ovf", 32'(ovf0), 32'd0);
        #1;
        check_val("c120_pulses",  32'(pulses0 - base0), 32'd10);
        check_val("c120_illegal", 32'(illegal0 - ill_base), 32'd0);

        // 1200 items: reach 99 then wrap (dut_wrap); saturate holds (dut_sat)
        @(negedge clk);
        do_reset();
        snap();
        items(1188);
        check_val("w_bcd99",  32'(bcd0), 32'h99);
        check_val("w_max99",  32'(max0), 32'd1);
        check_val("w_ovf99",  32'(ovf0), 32'd0);
        items(12);
        check_val("w_bcd00",  32'(bcd0), 32'h00);
        check_val("w_ovf",    32'(ovf0), 32'd1);
        check_val("w_max00",  32'(max0), 32'd0);
        check_val("w_gd",     32'(gd0),  32'd1);
        check_val("s_bcd100", 32'(bcd1), 32'h99);
        check_val("s_ovf100", 32'(ovf1), 32'd1);
        items(12);
        check_val("s_bcd",    32'(bcd1), 32'h99);
        check_val("s_max",    32'(max1), 32'd1);
        check_val("s_ovf",    32'(ovf1), 32'd1);
        check_val("s_ic",     32'(ic1),  32'd0);
        check_val("w_bcd01",  32'(bcd0), 32'h01);
        check_val("w_ovf_sticky", 32'(ovf0), 32'd1);
        #1;
        check_val("s_pulses", 32'(pulses1 - base1), 32'd101);
        check_val("w_illegal", 32'(illegal0 - ill_base), 32'd0);
        check_val("w_atmax_track", 32'(maxerr0), 32'd0);

        // Clear beats a simultaneous item and drops the sticky overflow
        @(negedge clk);
        items(5);
        check_val("cl_ic5",   32'(ic0),  32'd5);
        item  = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        item  = 1'b0;
        clear = 1'b0;
        check_val("cl_ic",    32'(ic0),  32'd0);
        check_val("cl_bcd",   32'(bcd0), 32'h00);
        check_val("cl_gd",    32'(gd0),  32'd0);
        check_val("cl_ovf",   32'(ovf0), 32'd0);
        check_val("cl_s_ovf", 32'(ovf1), 32'd0);
        items(12);
        check_val("cl_bcd12", 32'(bcd0), 32'h01);
        check_val("cl_ic12",  32'(ic0),  32'd0);

        // GROUP_SIZE=1, DIGITS=1
        @(negedge clk);
        do_reset();
        snap();
        items(9);
        check_val("one_bcd9", 32'(bcd2), 32'h9);
        check_val("one_max9", 32'(max2), 32'd1);
        check_val("one_ic",   32'(ic2),  32'd0);
        items(1);
        check_val("one_bcd0", 32'(bcd2), 32'h0);
        check_val("one_ovf",  32'(ovf2), 32'd1);
        check_val("one_max0", 32'(max2), 32'd0);
        items(1);
        check_val("one_bcd1", 32'(bcd2), 32'h1);
        #1;
        check_val("one_pulses", 32'(pulses2 - base2), 32'd11);

        // Reset mid-sequence, with an item and clear also present
        @(negedge clk);
        reset = 1'b1;
        item  = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        item  = 1'b0;
        clear = 1'b0;
        check_val("mr_bcd",   32'(bcd2), 32'h0);
        check_val("mr_ovf",   32'(ovf2), 32'd0);
        check_val("mr_gd",    32'(gd2),  32'd0);
        check_val("mr_w_ic",  32'(ic0),  32'd0);

        // Reset during a group_done pulse kills the pulse
        items(1);
        check_val("mp_gd1",   32'(gd2),  32'd1);
        do_reset();
        check_val("mp_gd0",   32'(gd2),  32'd0);
        check_val("mp_bcd",   32'(bcd2), 32'h0);
        items(1);
        check_val("resume_bcd", 32'(bcd2), 32'h1);
        check_val("resume_w_ic", 32'(ic0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/group_bcd_counter.md
GROUP_BCD_COUNTER -- requirements
Module: group_bcd_counter

Interface
REQ-001 Parameter GROUP_SIZE, default 12, items per completed group; legal range 1..65535.
REQ-002 Parameter DIGITS, default 2, number of BCD digits in the group tally; legal range 1..8.
REQ-003 Parameter SATURATE, default 0, tally overflow mode: 0 = wrap to zero, 1 = hold at all nines.
REQ-004 Derived width ICW SHALL be clog2(GROUP_SIZE) when GROUP_SIZE>1, else 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 item  input  1  one-cycle qualifier; each high cycle counts one item.
REQ-008 clear  input  1  synchronous soft clear of all counting state.
REQ-009 item_count  output  ICW  items accumulated in the current partial group, binary, 0..GROUP_SIZE-1.
REQ-010 bcd_groups  output  4*DIGITS  completed-group tally; digit k in bits [4k+3:4k]; digit 0 is units.
REQ-011 group_done  output  1  one-cycle pulse, high in the cycle the tally shows the newly completed group.
REQ-012 overflow  output  1  sticky flag, set when a completion occurs with the tally at all nines.
REQ-013 at_max  output  1  high while every digit of bcd_groups equals 9.

Function
REQ-014 All outputs SHALL be registered; an item sampled at edge N is reflected in outputs after edge N.
REQ-015 If item=1 and item_count<GROUP_SIZE-1, item_count SHALL increment by 1; the tally SHALL be unchanged; group_done=0 next cycle.
REQ-016 If item=1 and item_count==GROUP_SIZE-1, item_count SHALL return to 0, the tally SHALL increment by one group, and group_done=1 for exactly the next cycle.
REQ-017 With GROUP_SIZE=1, every item SHALL be a completion; item_count SHALL stay 0.
REQ-018 Tally increment SHALL be decimal: digit 0 +1; any digit at 9 SHALL become 0 and carry +1 into the next digit; no digit SHALL ever hold 10..15.
REQ-019 Completion with at_max=1 and SATURATE=0: tally SHALL wrap to all zeros, overflow SHALL set, group_done SHALL pulse.
REQ-020 Completion with at_max=1 and SATURATE=1: tally SHALL hold at all nines, overflow SHALL set, group_done SHALL pulse, item_count SHALL still wrap to 0.
REQ-021 overflow SHALL remain set until reset or clear; further overflows SHALL not alter it.
REQ-022 at_max SHALL be derived from the registered tally and SHALL track it in the same cycle.
REQ-023 item=0 cycles SHALL leave all state unchanged and drive group_done=0.
REQ-024 clear=1 SHALL, at the next edge, force item_count=0, bcd_groups=0, group_done=0, overflow=0, identical to reset.
REQ-025 clear and item in the same cycle: clear SHALL win; the item SHALL be discarded.
REQ-026 reset SHALL have priority over clear and item.

Reset
REQ-027 With reset high at an edge, the next cycle SHALL show item_count=0, bcd_groups=0, group_done=0, overflow=0, at_max=0 (at_max=0 because tally is 0).
REQ-028 reset asserted mid-group or mid-pulse SHALL discard the partial group and any pending group_done; no completion SHALL be reported for it.
REQ-029 Counting SHALL resume on the first item sampled with reset=0.

Verification
REQ-030 Defaults; 12 single-cycle items -> after 11th: item_count=11, tally 0x00; after 12th: item_count=0, bcd_groups=0x01, one group_done pulse.
REQ-031 Defaults; 120 items continuous -> bcd_groups=0x10 (carry 09->10), exactly 10 group_done pulses, no illegal digit.
REQ-032 Defaults SATURATE=0; 1200 items -> bcd_groups=0x00 after 99->wrap, overflow=1, at_max=1 during tally 0x99, 0 after.
REQ-033 SATURATE=1; 1212 items -> bcd_groups=0x99, at_max=1, overflow=1, 101 group_done pulses, item_count=0.
REQ-034 Defaults; 5 items, then item and clear in the same cycle -> all outputs 0; next 12 items -> bcd_groups=0x01.
REQ-035 GROUP_SIZE=1, DIGITS=1; 11 items -> bcd_groups=0x1 after wrap at 10th item, overflow=1, 11 group_done pulses; reset mid-sequence -> all outputs 0 next cycle.
